// File: rtl/pixel_generator.sv
// Mandelbrot video source: one iterative Q8.24 engine, 4-pixel/3-word packer, AXI4-Stream out, AXI4-Lite view registers.
// Build macro TEST_PATTERN_EN adds an x/y gradient selected by register 0x10 bit0.
module pixel_generator #(
    parameter int X_PIX   = 640,
    parameter int Y_LINES = 480,
    parameter int ITER_W  = 8
) (
    input  logic        out_stream_aclk,
    input  logic        s_axi_lite_aclk,
    input  logic        axi_resetn,
    input  logic        periph_resetn,
    output logic [31:0] out_stream_tdata,
    output logic [3:0]  out_stream_tkeep,
    output logic        out_stream_tlast,
    output logic        out_stream_tuser,
    output logic        out_stream_tvalid,
    input  logic        out_stream_tready,
    input  logic [7:0]  s_axi_lite_awaddr,
    input  logic        s_axi_lite_awvalid,
    output logic        s_axi_lite_awready,
    input  logic [31:0] s_axi_lite_wdata,
    input  logic        s_axi_lite_wvalid,
    output logic        s_axi_lite_wready,
    output logic [1:0]  s_axi_lite_bresp,
    output logic        s_axi_lite_bvalid,
    input  logic        s_axi_lite_bready,
    input  logic [7:0]  s_axi_lite_araddr,
    input  logic        s_axi_lite_arvalid,
    output logic        s_axi_lite_arready,
    output logic [31:0] s_axi_lite_rdata,
    output logic [1:0]  s_axi_lite_rresp,
    output logic        s_axi_lite_rvalid,
    input  logic        s_axi_lite_rready,
    output logic [7:0]  r_out,
    output logic [7:0]  g_out,
    output logic [7:0]  b_out,
    output logic [10:0] x_out,
    output logic [10:0] y_out,
    output logic        valid_int_out
);
    localparam int WPL  = X_PIX * 3 / 4;
    localparam int WC_W = (WPL > 1) ? $clog2(WPL) : 1;
    localparam int LC_W = (Y_LINES > 1) ? $clog2(Y_LINES) : 1;
    localparam logic [31:0] MAX_CLAMP = 32'(2 ** ITER_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_INIT, S_ITER, S_DONE} state_t;

    logic w_rst_n;
    assign w_rst_n = axi_resetn & periph_resetn;

    // ---------------- AXI4-Lite register file ----------------
    logic        r_awready, r_bvalid, r_arready, r_rvalid;
    logic [31:0] r_rdata, w_rmux;
    logic [31:0] r_reg_x0, r_reg_y0, r_reg_step, r_reg_max;
    logic        w_reg_pat;

`ifdef TEST_PATTERN_EN
    logic r_reg_pat;
    assign w_reg_pat = r_reg_pat;
`else
    assign w_reg_pat = 1'b0;
`endif

    always_comb begin
        w_rmux = 32'd0;
        case (s_axi_lite_araddr)
            8'h00:   w_rmux = r_reg_x0;
            8'h04:   w_rmux = r_reg_y0;
            8'h08:   w_rmux = r_reg_step;
            8'h0C:   w_rmux = r_reg_max;
            8'h10:   w_rmux = {31'd0, w_reg_pat};
            default: w_rmux = 32'd0;
        endcase
    end

    always_ff @(posedge out_stream_aclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_awready  <= 1'b0;
            r_bvalid   <= 1'b0;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= 32'd0;
            r_reg_x0   <= 32'hFD80_0000;
            r_reg_y0   <= 32'h0150_0000;
            r_reg_step <= 32'h0001_6666;
            r_reg_max  <= 32'd64;
`ifdef TEST_PATTERN_EN
            r_reg_pat  <= 1'b0;
`endif
        end else begin
            // awready/wready is a one-cycle pulse; the register is written on that handshake
            if (r_awready) begin
                r_awready <= 1'b0;
                r_bvalid  <= 1'b1;
                case (s_axi_lite_awaddr)
                    8'h00: r_reg_x0   <= s_axi_lite_wdata;
                    8'h04: r_reg_y0   <= s_axi_lite_wdata;
                    8'h08: r_reg_step <= s_axi_lite_wdata;
                    8'h0C: r_reg_max  <= (s_axi_lite_wdata > MAX_CLAMP) ? MAX_CLAMP : s_axi_lite_wdata;
`ifdef TEST_PATTERN_EN
                    8'h10: r_reg_pat  <= s_axi_lite_wdata[0];
`endif
                    default: ;
                endcase
            end else if (s_axi_lite_awvalid && s_axi_lite_wvalid && !r_bvalid) begin
                r_awready <= 1'b1;
            end
            if (r_bvalid && s_axi_lite_bready) r_bvalid <= 1'b0;

            if (r_arready) begin
                r_arready <= 1'b0;
                r_rvalid  <= 1'b1;
                r_rdata   <= w_rmux;
            end else if (s_axi_lite_arvalid && !r_rvalid) begin
                r_arready <= 1'b1;
            end
            if (r_rvalid && s_axi_lite_rready) r_rvalid <= 1'b0;
        end
    end

    assign s_axi_lite_awready = r_awready;
    assign s_axi_lite_wready  = r_awready;
    assign s_axi_lite_bvalid  = r_bvalid;
    assign s_axi_lite_bresp   = 2'b00;
    assign s_axi_lite_arready = r_arready;
    assign s_axi_lite_rvalid  = r_rvalid;
    assign s_axi_lite_rdata   = r_rdata;
    assign s_axi_lite_rresp   = 2'b00;

    // ---------------- Mandelbrot engine ----------------
    state_t                   r_st;
    logic [10:0]              r_x, r_y, w_nx, w_ny;
    logic signed [31:0]       r_cre, r_cim, r_zre, r_zim;
    logic [ITER_W-1:0]        r_n, r_sh_max, w_max;
    logic [31:0]              r_sh_x0, r_sh_y0, r_sh_step, w_x0, w_y0;
    logic signed [31:0]       w_step;
    logic                     r_sh_pat, w_pat, w_first, w_push, w_esc;
    logic [23:0]              r_pix;
    logic [7:0]               r_rout, r_gout, r_bout;
    logic [10:0]              r_xout, r_yout;
    logic                     r_vint;
    logic signed [63:0]       w_xm, w_ym, w_rr, w_ii, w_ri;
    logic signed [31:0]       w_rr_q, w_ii_q, w_ri_q, w_zre_n, w_zim_n;
    logic signed [32:0]       w_mag;

    // Pixel (0,0) reads the live registers, which are captured into the shadows that same cycle
    assign w_first = (r_x == 11'd0) && (r_y == 11'd0);
    assign w_x0    = w_first ? r_reg_x0 : r_sh_x0;
    assign w_y0    = w_first ? r_reg_y0 : r_sh_y0;
    assign w_step  = w_first ? r_reg_step : r_sh_step;
    assign w_max   = w_first ? r_reg_max[ITER_W-1:0] : r_sh_max;
    assign w_pat   = w_first ? w_reg_pat : r_sh_pat;

    assign w_xm    = 64'($signed({1'b0, r_x})) * 64'(w_step);
    assign w_ym    = 64'($signed({1'b0, r_y})) * 64'(w_step);
    assign w_rr    = 64'(r_zre) * 64'(r_zre);
    assign w_ii    = 64'(r_zim) * 64'(r_zim);
    assign w_ri    = 64'(r_zre) * 64'(r_zim);
    assign w_rr_q  = w_rr[55:24];
    assign w_ii_q  = w_ii[55:24];
    assign w_ri_q  = w_ri[55:24];
    assign w_mag   = {w_rr_q[31], w_rr_q} + {w_ii_q[31], w_ii_q};
    assign w_esc   = w_mag > 33'sh004000000;
    assign w_zre_n = w_rr_q - w_ii_q + r_cre;
    assign w_zim_n = {w_ri_q[30:0], 1'b0} + r_cim;

    assign w_nx = (r_x == 11'(X_PIX - 1)) ? 11'd0 : r_x + 11'd1;
    assign w_ny = (r_x != 11'(X_PIX - 1)) ? r_y :
                  (r_y == 11'(Y_LINES - 1)) ? 11'd0 : r_y + 11'd1;

    function automatic logic [23:0] f_colour(input logic [ITER_W-1:0] n, input logic [ITER_W-1:0] mx);
        logic [7:0] n8;
        n8 = 8'(n);
        if (n == mx) return 24'd0;
        return {n8, n8[6:0], 1'b0, n8[5:0], 2'b00};
    endfunction

    function automatic logic [23:0] f_grad(input logic [10:0] x, input logic [10:0] y);
        return {x[7:0], y[7:0], x[7:0] ^ y[7:0]};
    endfunction

    always_ff @(posedge out_stream_aclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_st      <= S_IDLE;
            r_x       <= 11'd0;
            r_y       <= 11'd0;
            r_cre     <= 32'sd0;
            r_cim     <= 32'sd0;
            r_zre     <= 32'sd0;
            r_zim     <= 32'sd0;
            r_n       <= '0;
            r_sh_x0   <= 32'hFD80_0000;
            r_sh_y0   <= 32'h0150_0000;
            r_sh_step <= 32'h0001_6666;
            r_sh_max  <= ITER_W'(64);
            r_sh_pat  <= 1'b0;
            r_pix     <= 24'd0;
            r_rout    <= 8'd0;
            r_gout    <= 8'd0;
            r_bout    <= 8'd0;
            r_xout    <= 11'd0;
            r_yout    <= 11'd0;
            r_vint    <= 1'b0;
        end else begin
            r_vint <= 1'b0;
            case (r_st)
                S_IDLE: r_st <= S_INIT;
                S_INIT: begin
                    if (w_first) begin
                        r_sh_x0   <= r_reg_x0;
                        r_sh_y0   <= r_reg_y0;
                        r_sh_step <= r_reg_step;
                        r_sh_max  <= r_reg_max[ITER_W-1:0];
                        r_sh_pat  <= w_reg_pat;
                    end
                    r_cre <= w_x0 + w_xm[31:0];
                    r_cim <= w_y0 - w_ym[31:0];
                    r_zre <= 32'sd0;
                    r_zim <= 32'sd0;
                    r_n   <= '0;
                    if (w_pat) begin
                        r_pix <= f_grad(r_x, r_y);
                        r_st  <= S_DONE;
                    end else if (w_max == '0) begin
                        r_pix <= 24'd0;
                        r_st  <= S_DONE;
                    end else begin
                        r_st  <= S_ITER;
                    end
                end
                S_ITER: begin
                    if (w_esc || (r_n == r_sh_max)) begin
                        r_pix <= f_colour(r_n, r_sh_max);
                        r_st  <= S_DONE;
                    end else begin
                        r_zre <= w_zre_n;
                        r_zim <= w_zim_n;
                        r_n   <= r_n + 1'b1;
                    end
                end
                default: begin
                    if (w_push) begin
                        r_vint <= 1'b1;
                        r_rout <= r_pix[23:16];
                        r_gout <= r_pix[15:8];
                        r_bout <= r_pix[7:0];
                        r_xout <= r_x;
                        r_yout <= r_y;
                        r_x    <= w_nx;
                        r_y    <= w_ny;
                        // Gradient streams at one pixel per cycle; frame start goes back through INIT to relatch
                        if (r_sh_pat && !((w_nx == 11'd0) && (w_ny == 11'd0))) r_pix <= f_grad(w_nx, w_ny);
                        else r_st <= S_INIT;
                    end
                end
            endcase
        end
    end

    assign r_out = r_rout;
    assign g_out = r_gout;
    assign b_out = r_bout;
    assign x_out = r_xout;
    assign y_out = r_yout;
    assign valid_int_out = r_vint;

    // ---------------- Packer + 2-deep output queue ----------------
    logic [1:0]      r_ph;
    logic [23:0]     r_part;
    logic [WC_W-1:0] r_wc;
    logic [LC_W-1:0] r_lc;
    logic [33:0]     r_oq, r_stg, w_went;
    logic            r_ovld, r_stg_vld, w_wvld, w_pop;
    logic [31:0]     w_word;

    always_comb begin
        w_word = 32'd0;
        case (r_ph)
            2'd1:    w_word = {r_pix[7:0], r_part[23:0]};
            2'd2:    w_word = {r_pix[15:0], r_part[15:0]};
            2'd3:    w_word = {r_pix[23:0], r_part[7:0]};
            default: w_word = 32'd0;
        endcase
    end

    // Phase 0 only fills the partial word; any other phase completes one word and needs a free slot
    assign w_push = (r_st == S_DONE) && ((r_ph == 2'd0) || !r_stg_vld);
    assign w_wvld = w_push && (r_ph != 2'd0);
    assign w_pop  = r_ovld && out_stream_tready;
    assign w_went = {(r_wc == '0) && (r_lc == '0), r_wc == WC_W'(WPL - 1), w_word};

    always_ff @(posedge out_stream_aclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_ph      <= 2'd0;
            r_part    <= 24'd0;
            r_wc      <= '0;
            r_lc      <= '0;
            r_oq      <= 34'd0;
            r_ovld    <= 1'b0;
            r_stg     <= 34'd0;
            r_stg_vld <= 1'b0;
        end else begin
            if (w_push) begin
                r_ph <= r_ph + 2'd1;
                case (r_ph)
                    2'd0:    r_part <= r_pix;
                    2'd1:    r_part <= {8'd0, r_pix[23:8]};
                    2'd2:    r_part <= {16'd0, r_pix[23:16]};
                    default: r_part <= 24'd0;
                endcase
            end
            if (w_wvld) begin
                if (r_wc == WC_W'(WPL - 1)) begin
                    r_wc <= '0;
                    r_lc <= (r_lc == LC_W'(Y_LINES - 1)) ? '0 : r_lc + 1'b1;
                end else begin
                    r_wc <= r_wc + 1'b1;
                end
            end
            case ({w_wvld, w_pop})
                2'b11: begin
                    if (r_stg_vld) begin
                        r_oq  <= r_stg;
                        r_stg <= w_went;
                    end else begin
                        r_oq  <= w_went;
                    end
                end
                2'b10: begin
                    if (!r_ovld) begin
                        r_oq      <= w_went;
                        r_ovld    <= 1'b1;
                    end else begin
                        r_stg     <= w_went;
                        r_stg_vld <= 1'b1;
                    end
                end
                2'b01: begin
                    if (r_stg_vld) begin
                        r_oq      <= r_stg;
                        r_stg_vld <= 1'b0;
                    end else begin
                        r_ovld    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_stream_tdata  = r_oq[31:0];
    assign out_stream_tlast  = r_oq[32];
    assign out_stream_tuser  = r_oq[33];
    assign out_stream_tvalid = r_ovld;
    assign out_stream_tkeep  = 4'hF;

    logic w_unused;
    assign w_unused = ^{s_axi_lite_aclk, w_xm[63:32], w_ym[63:32], w_rr[63:56], w_rr[23:0],
                        w_ii[63:56], w_ii[23:0], w_ri[63:56], w_ri[23:0], w_ri_q[31]};
endmodule

// File: tb/tb_pixel_generator.sv
// Directed bench for pixel_generator on a reduced 8x4 frame (6 words/line, 24 words/frame).
module tb_pixel_generator;
    localparam int XP = 8, YL = 4;

    logic        clk = 1'b0;
    logic        axi_resetn, periph_resetn;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast, tuser, tvalid, tready;
    logic [7:0]  awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] wdata, rdata;
    logic [1:0]  bresp, rresp;
    logic        arvalid, arready, rvalid, rready;
    logic [7:0]  r_o, g_o, b_o;
    logic [10:0] x_o, y_o;
    logic        vint;

    always #5 clk = ~clk;

    pixel_generator #(.X_PIX(XP), .Y_LINES(YL), .ITER_W(8)) dut (
        .out_stream_aclk(clk), .s_axi_lite_aclk(clk),
        .axi_resetn(axi_resetn), .periph_resetn(periph_resetn),
        .out_stream_tdata(tdata), .out_stream_tkeep(tkeep), .out_stream_tlast(tlast),
        .out_stream_tuser(tuser), .out_stream_tvalid(tvalid), .out_stream_tready(tready),
        .s_axi_lite_awaddr(awaddr), .s_axi_lite_awvalid(awvalid), .s_axi_lite_awready(awready),
        .s_axi_lite_wdata(wdata), .s_axi_lite_wvalid(wvalid), .s_axi_lite_wready(wready),
        .s_axi_lite_bresp(bresp), .s_axi_lite_bvalid(bvalid), .s_axi_lite_bready(bready),
        .s_axi_lite_araddr(araddr), .s_axi_lite_arvalid(arvalid), .s_axi_lite_arready(arready),
        .s_axi_lite_rdata(rdata), .s_axi_lite_rresp(rresp), .s_axi_lite_rvalid(rvalid),
        .s_axi_lite_rready(rready),
        .r_out(r_o), .g_out(g_o), .b_out(b_o), .x_out(x_o), .y_out(y_o), .valid_int_out(vint)
    );

    int n_tot = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Pixel strobe log: {x,y,rgb} and the cycle it was seen
    int          cyc = 0;
    logic [45:0] sq[$];
    int          sc[$];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (vint) begin
        sq.push_back({x_o, y_o, r_o, g_o, b_o});
        sc.push_back(cyc);
    end

    bit          rnd_rdy = 1'b0, prev_stall = 1'b0;
    logic [33:0] prev_w;
    int          max_gap = 0, stab_err = 0;

    task automatic get_word(output logic [33:0] w);
        int gap = 0;
        bit got = 1'b0;
        logic [33:0] cur;
        w = '0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            cur = {tuser, tlast, tdata};
            if (prev_stall && (!tvalid || cur != prev_w)) stab_err++;
            prev_stall = tvalid && !tready;
            prev_w = cur;
            gap = tvalid ? 0 : gap + 1;
            if (gap > max_gap) max_gap = gap;
            if (tvalid && tready) begin
                w = cur;
                got = 1'b1;
            end
        end
        if (!got) chk("word_timeout", 64'd0, 64'd1);
    endtask

    task automatic axi_wr(input logic [7:0] a, input logic [31:0] d);
        bit ok = 1'b0;
        @(negedge clk);
        tready = 1'b0; prev_stall = 1'b0;
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (awready && wready) ok = 1'b1;
        end
        if (!ok) chk("awready_timeout", 64'd0, 64'd1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        chk("bvalid_bresp", {61'd0, bvalid, bresp}, {61'd0, 1'b1, 2'b00});
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_rd(input logic [7:0] a, output logic [31:0] d);
        bit ok = 1'b0;
        @(negedge clk);
        tready = 1'b0; prev_stall = 1'b0;
        araddr = a; arvalid = 1'b1; rready = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (arready) ok = 1'b1;
        end
        if (!ok) chk("arready_timeout", 64'd0, 64'd1);
        @(negedge clk);
        arvalid = 1'b0;
        chk("rvalid_rresp", {61'd0, rvalid, rresp}, {61'd0, 1'b1, 2'b00});
        d = rdata;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    // Every pixel of the 8x4 default view escapes at n=1 -> pixel 0x010204 everywhere
    function automatic logic [33:0] exp_w(input int k, input bit blank);
        logic [31:0] d;
        case (k % 3)
            0:       d = 32'h0401_0204;
            1:       d = 32'h0204_0102;
            default: d = 32'h0102_0401;
        endcase
        if (blank) d = 32'd0;
        return {(k % 24) == 0, (k % 6) == 5, d};
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [33:0] w;
        axi_resetn = 1'b0; periph_resetn = 1'b0; tready = 1'b0;
        awaddr = 8'd0; awvalid = 1'b0; wdata = 32'd0; wvalid = 1'b0; bready = 1'b0;
        araddr = 8'd0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_stream", {25'd0, tvalid, tuser, tlast, tkeep, tdata}, {25'd0, 3'b000, 4'hF, 32'd0});
        chk("rst_pix", {17'd0, vint, r_o, g_o, b_o, x_o, y_o}, 64'd0);
        chk("rst_axi", {59'd0, awready, wready, bvalid, arready, rvalid}, 64'd0);
        axi_resetn = 1'b1; periph_resetn = 1'b1;

        axi_rd(8'h00, d); chk("def_x0", 64'(d), 64'hFD80_0000);
        axi_rd(8'h04, d); chk("def_y0", 64'(d), 64'h0150_0000);
        axi_rd(8'h08, d); chk("def_step", 64'(d), 64'h0001_6666);
        axi_rd(8'h0C, d); chk("def_max", 64'(d), 64'd64);
        axi_rd(8'h10, d); chk("rd_0x10", 64'(d), 64'd0);
        axi_rd(8'h20, d); chk("rd_unmapped", 64'(d), 64'd0);

        for (int i = 0; i < 200 && sq.size() == 0; i++) @(negedge clk);
        if (sq.size() == 0) chk("pix0_timeout", 64'd0, 64'd1);
        else chk("pix0", 64'(sq[0]), 64'({11'd0, 11'd0, 24'h010204}));

        // frame 1 and first line of frame 2
        for (int k = 0; k < 30; k++) begin
            get_word(w);
            chk($sformatf("f1_w%0d", k), 64'(w), 64'(exp_w(k, 1'b0)));
        end

        // mid-frame register updates must only affect the next frame
        axi_wr(8'h0C, 32'd300);
        axi_rd(8'h0C, d); chk("max_clamp", 64'(d), 64'd255);
        axi_wr(8'h0C, 32'd0);
        axi_wr(8'h08, 32'h0002_0000);
        axi_rd(8'h08, d); chk("step_rb", 64'(d), 64'h0002_0000);
        axi_wr(8'h24, 32'h1234_5678);
        axi_rd(8'h24, d); chk("wr_unmapped", 64'(d), 64'd0);

        for (int k = 30; k < 48; k++) begin
            get_word(w);
            chk($sformatf("f2_w%0d", k), 64'(w), 64'(exp_w(k, 1'b0)));
        end
        for (int k = 0; k < 24; k++) begin
            get_word(w);
            chk($sformatf("f3_w%0d", k), 64'(w), 64'(exp_w(k, 1'b1)));
        end

        @(negedge clk); tready = 1'b0;
        repeat (4) @(negedge clk);
        if (sq.size() < 96) chk("pix_count", 64'(sq.size()), 64'd96);
        else begin
            for (int i = 0; i < 96; i++)
                chk($sformatf("pix%0d", i), 64'(sq[i]),
                    64'({11'(i % XP), 11'((i / XP) % YL), (i < 64) ? 24'h010204 : 24'h000000}));
            for (int i = 65; i < 96; i++)
                chk($sformatf("rate%0d", i), 64'(sc[i] - sc[i - 1] <= 2), 64'd1);
        end

        // reset in the middle of a line
        for (int k = 0; k < 3; k++) begin
            get_word(w);
            chk($sformatf("f4_w%0d", k), 64'(w), 64'(exp_w(k, 1'b1)));
        end
        @(negedge clk);
        tready = 1'b0;
        axi_resetn = 1'b0;
        #1;
        chk("mid_rst_stream", {25'd0, tvalid, tuser, tlast, tkeep, tdata}, {25'd0, 3'b000, 4'hF, 32'd0});
        chk("mid_rst_pix", {17'd0, vint, r_o, g_o, b_o, x_o, y_o}, 64'd0);
        repeat (2) @(negedge clk);
        axi_resetn = 1'b1;
        axi_rd(8'h0C, d); chk("rst_max", 64'(d), 64'd64);

        // random backpressure: same word sequence, stable while stalled, bounded gaps
        rnd_rdy = 1'b1; prev_stall = 1'b0; stab_err = 0; max_gap = 0;
        for (int k = 0; k < 48; k++) begin
            get_word(w);
            chk($sformatf("rnd_w%0d", k), 64'(w), 64'(exp_w(k, 1'b0)));
        end
        chk("stall_stable", 64'(stab_err), 64'd0);
        chk("tvalid_gap_lt_1000", 64'(max_gap < 1000), 64'd1);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
